// File: rtl/jt1943_romslot_arb_if.sv
`default_nettype none
// ============================================================================
// Module  : jt1943_romslot_arb_if
// Brief   : Slot-request and SDRAM read-port bundle for the ROM slot arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface jt1943_romslot_arb_if #(
    parameter int AW = 22
);
    // Slot (cache) side
    logic            slot_cen;
    logic [3:0]      slot_req;
    logic [4*AW-1:0] slot_addr;
    logic [3:0]      slot_we;
    logic [31:0]     data_out;
    // SDRAM controller side
    logic [AW-1:0]   sdram_addr;
    logic            sdram_rd;
    logic            sdram_ack;
    logic            data_rdy;
    logic [31:0]     data_read;

    // master: the arbiter itself
    modport master (
        input  slot_cen, slot_req, slot_addr, sdram_ack, data_rdy, data_read,
        output slot_we, data_out, sdram_addr, sdram_rd
    );

    // slave: the slot caches plus the SDRAM controller surrounding it
    modport slave (
        output slot_cen, slot_req, slot_addr, sdram_ack, data_rdy, data_read,
        input  slot_we, data_out, sdram_addr, sdram_rd
    );
endinterface
`default_nettype wire

// File: rtl/jt1943_romslot_arb.sv
`default_nettype none
// ============================================================================
// Module  : jt1943_romslot_arb
// Brief   : Serialises four ROM slot requests onto one SDRAM read port and
//           returns each word with a per-slot strobe held until slot_cen.
//           Define JT1943_ARB_RR_EN for round-robin instead of fixed priority.
// Revision: 1.0 - initial release
// ============================================================================
module jt1943_romslot_arb #(
    parameter int            AW           = 22,
    parameter logic [AW-1:0] SLOT0_OFFSET = '0,
    parameter logic [AW-1:0] SLOT1_OFFSET = '0,
    parameter logic [AW-1:0] SLOT2_OFFSET = '0,
    parameter logic [AW-1:0] SLOT3_OFFSET = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    jt1943_romslot_arb_if.master   bus
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_DELIVER   = 2'd3
    } state_t;

    state_t        r_state;
    logic [1:0]    r_idx;
    logic [AW-1:0] r_lat_addr;
    logic [AW-1:0] r_addr;
    logic          r_rd;
    logic [3:0]    r_we;
    logic [31:0]   r_data;

    logic [AW-1:0] w_slot_addr [4];
    logic [1:0]    w_start;
    logic [1:0]    w_cand;
    logic [1:0]    w_sel;
    logic          w_found;
    logic [AW-1:0] w_offset;
    logic [AW-1:0] w_req_addr;
    logic          w_match;

    for (genvar i = 0; i < 4; i++) begin : g_slot
        assign w_slot_addr[i] = bus.slot_addr[i*AW +: AW];
    end

`ifdef JT1943_ARB_RR_EN
    logic [1:0] r_last;
    assign w_start = r_last + 2'd1;
`else
    assign w_start = 2'd0;
`endif

    // First requesting slot found when scanning upward (mod 4) from w_start
    always_comb begin
        w_sel   = w_start;
        w_cand  = w_start;
        w_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_cand = w_start + 2'(i);
            if (!w_found && bus.slot_req[w_cand]) begin
                w_sel   = w_cand;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_offset = SLOT0_OFFSET;
        case (w_sel)
            2'd0:    w_offset = SLOT0_OFFSET;
            2'd1:    w_offset = SLOT1_OFFSET;
            2'd2:    w_offset = SLOT2_OFFSET;
            default: w_offset = SLOT3_OFFSET;
        endcase
    end

    assign w_req_addr = w_slot_addr[w_sel] + w_offset;
    // A slot that moved on would tag the word with the wrong address
    assign w_match    = (w_slot_addr[r_idx] == r_lat_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= 2'd0;
            r_lat_addr <= '0;
            r_addr     <= '0;
            r_rd       <= 1'b0;
            r_we       <= 4'b0000;
            r_data     <= 32'd0;
`ifdef JT1943_ARB_RR_EN
            r_last     <= 2'd3;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_we <= 4'b0000;
                    if (w_found) begin
                        r_idx      <= w_sel;
                        r_lat_addr <= w_slot_addr[w_sel];
                        r_addr     <= w_req_addr;
                        r_rd       <= 1'b1;
                        r_state    <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (bus.sdram_ack) begin
                        r_rd    <= 1'b0;
                        r_state <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (bus.data_rdy) begin
                        r_data  <= bus.data_read;
                        r_we    <= 4'b0001 << r_idx;
                        r_state <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (!w_match || bus.slot_cen) begin
                        r_we    <= 4'b0000;
                        r_state <= ST_IDLE;
`ifdef JT1943_ARB_RR_EN
                        r_last  <= r_idx;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.slot_we    = r_we;
    assign bus.data_out   = r_data;
    assign bus.sdram_addr = r_addr;
    assign bus.sdram_rd   = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_jt1943_romslot_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_jt1943_romslot_arb
// Brief   : Directed scoreboard bench for the ROM slot arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_jt1943_romslot_arb;

    localparam int AW = 22;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [AW-1:0] exp_addr_q [$];
    logic [35:0]   exp_del_q  [$];

    jt1943_romslot_arb_if #(.AW(AW)) bus ();

    jt1943_romslot_arb #(
        .AW           (AW),
        .SLOT0_OFFSET (22'h000000),
        .SLOT1_OFFSET (22'h020000),
        .SLOT2_OFFSET (22'h000000),
        .SLOT3_OFFSET (22'h3FFFF0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: samples just before each rising edge
    logic          prev_rd = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (bus.sdram_rd && !prev_rd) begin
                if (exp_addr_q.size() == 0) chk("unexpected_read", 64'(bus.sdram_addr), 64'hFFFF_FFFF);
                else chk("read_addr", 64'(bus.sdram_addr), 64'(exp_addr_q.pop_front()));
            end
            if (bus.sdram_rd && prev_rd)
                chk("read_addr_hold", 64'(bus.sdram_addr), 64'(prev_addr));
            if (bus.slot_we != 4'b0000 && bus.slot_cen) begin
                if (exp_del_q.size() == 0) chk("unexpected_strobe", 64'({bus.slot_we, bus.data_out}), 64'hFFFF_FFFF_F);
                else chk("delivery", 64'({bus.slot_we, bus.data_out}), 64'(exp_del_q.pop_front()));
            end
        end
        prev_rd   = bus.sdram_rd;
        prev_addr = bus.sdram_addr;
    end

    function automatic logic [AW-1:0] mapped(input logic [1:0] s);
        case (s)
            2'd0:    return 22'h000011;
            2'd1:    return 22'h020022;
            2'd2:    return 22'h000040;
            default: return 22'h000010;   // 0x20 + 0x3FFFF0 wraps
        endcase
    endfunction

    // One SDRAM transaction; returns on the negedge after the strobe rises
    task automatic xact(input logic [1:0] slot, input logic [AW-1:0] ea,
                        input logic [31:0] d, input int ack_dly, input bit deliver);
        int n;
        logic [3:0] m;
        m = 4'b0001 << slot;
        exp_addr_q.push_back(ea);
        if (deliver) exp_del_q.push_back({m, d});
        n = 0;
        while (!bus.sdram_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.sdram_rd) begin
            chk("read_timeout", 64'd0, 64'd1);
            return;
        end
        for (int i = 0; i < ack_dly; i++) begin
            chk("rd_before_ack", 64'(bus.sdram_rd), 64'd1);
            chk("we_before_ack", 64'(bus.slot_we), 64'd0);
            @(negedge clk);
        end
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
        chk("rd_after_ack", 64'(bus.sdram_rd), 64'd0);
        bus.data_rdy  = 1'b1;
        bus.data_read = d;
        @(negedge clk);
        bus.data_rdy  = 1'b0;
        chk("we_after_rdy", 64'(bus.slot_we), 64'(m));
        chk("data_after_rdy", 64'(bus.data_out), 64'(d));
    endtask

    logic [1:0] order [4];

    initial begin
        rst           = 1'b1;
        bus.slot_cen  = 1'b0;
        bus.slot_req  = 4'b0000;
        bus.slot_addr = '0;
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        bus.data_read = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_we",   64'(bus.slot_we),    64'd0);
        chk("reset_data", 64'(bus.data_out),   64'd0);
        chk("reset_addr", 64'(bus.sdram_addr), 64'd0);
        chk("reset_rd",   64'(bus.sdram_rd),   64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_req_rd", 64'(bus.sdram_rd), 64'd0);

        // Contention on slots 0,1,3 with strobes consumed immediately
`ifdef JT1943_ARB_RR_EN
        order = '{2'd0, 2'd1, 2'd3, 2'd0};
`else
        order = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
        bus.slot_addr[0*AW +: AW] = 22'h000011;
        bus.slot_addr[1*AW +: AW] = 22'h000022;
        bus.slot_addr[3*AW +: AW] = 22'h000020;
        bus.slot_cen = 1'b1;
        bus.slot_req = 4'b1011;
        for (int k = 0; k < 4; k++)
            xact(order[k], mapped(order[k]), 32'hC0DE_0000 + 32'(k), 0, 1'b1);
        bus.slot_req = 4'b0000;
        repeat (2) @(negedge clk);

        // Single request on slot 1, strobe held while cen is low
        bus.slot_cen = 1'b0;
        bus.slot_addr[1*AW +: AW] = 22'h000100;
        bus.slot_req = 4'b0010;
        @(negedge clk);
        chk("single_rd_latency", 64'(bus.sdram_rd), 64'd1);
        chk("single_addr", 64'(bus.sdram_addr), 64'h020100);
        xact(2'd1, 22'h020100, 32'hDEAD_BEEF, 0, 1'b1);
        bus.slot_req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("we_held", 64'(bus.slot_we), 64'b0010);
            chk("data_held", 64'(bus.data_out), 64'hDEAD_BEEF);
        end
        bus.slot_cen = 1'b1;
        @(negedge clk);
        chk("we_cleared_after_cen", 64'(bus.slot_we), 64'd0);
        repeat (2) @(negedge clk);

        // Offset wrap on slot 3
        bus.slot_addr[3*AW +: AW] = 22'h000020;
        bus.slot_req = 4'b1000;
        xact(2'd3, 22'h000010, 32'h3333_0010, 0, 1'b1);
        bus.slot_req = 4'b0000;
        repeat (2) @(negedge clk);

        // Delayed acknowledge on slot 2
        bus.slot_addr[2*AW +: AW] = 22'h000040;
        bus.slot_req = 4'b0100;
        xact(2'd2, 22'h000040, 32'h4444_0040, 5, 1'b1);
        bus.slot_req = 4'b0000;
        repeat (2) @(negedge clk);

        // Slot 2 moves on while its word waits: discard and re-read
        bus.slot_cen = 1'b0;
        bus.slot_req = 4'b0100;
        xact(2'd2, 22'h000040, 32'hAAAA_0040, 0, 1'b0);
        bus.slot_addr[2*AW +: AW] = 22'h000044;
        @(negedge clk);
        chk("abort_we", 64'(bus.slot_we), 64'd0);
        xact(2'd2, 22'h000044, 32'hAAAA_0044, 0, 1'b1);
        bus.slot_cen = 1'b1;
        bus.slot_req = 4'b0000;
        @(negedge clk);
        chk("reread_consumed", 64'(bus.slot_we), 64'd0);
        repeat (2) @(negedge clk);

        // Reset while waiting for data
        bus.slot_addr[0*AW +: AW] = 22'h000055;
        bus.slot_req = 4'b0001;
        exp_addr_q.push_back(22'h000055);
        for (int n = 0; n < 20 && !bus.sdram_rd; n++) @(negedge clk);
        chk("rst_case_rd", 64'(bus.sdram_rd), 64'd1);
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
        rst = 1'b1;
        bus.slot_req = 4'b0000;
        @(negedge clk);
        chk("rst_mid_rd", 64'(bus.sdram_rd), 64'd0);
        chk("rst_mid_we", 64'(bus.slot_we), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'h0000_0BAD;
        @(negedge clk);
        bus.data_rdy  = 1'b0;
        chk("stale_rdy_we", 64'(bus.slot_we), 64'd0);
        chk("stale_rdy_data", 64'(bus.data_out), 64'd0);
        repeat (3) @(negedge clk);

        chk("addr_queue_empty", 64'(exp_addr_q.size()), 64'd0);
        chk("deliver_queue_empty", 64'(exp_del_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/jt1943_romslot_arb.md
Name: jt1943_romslot_arb

Overview:
Downstream companion of the per-client ROM request caches. It collects up to four slot requests (req, word-aligned addr_req), serialises them onto a single SDRAM read port, and returns each 32-bit word with a per-slot write strobe. The strobe is held until the slot's clock enable samples it. It sits between the video/CPU ROM clients and the SDRAM controller.

Parameters:
AW, 22, address width of slots and of the SDRAM word address.
SLOT0_OFFSET, 0, AW-bit base added to slot 0 address.
SLOT1_OFFSET, 0, AW-bit base added to slot 1 address.
SLOT2_OFFSET, 0, AW-bit base added to slot 2 address.
SLOT3_OFFSET, 0, AW-bit base added to slot 3 address.

Ports:
clk  in  1  system clock.
rst  in  1  reset; synchronous, active-high.
slot_cen  in  1  clock enable shared by the slot caches; their write takes effect on the edge where cen and we are both high.
slot_req  in  4  request per slot; bit n belongs to slot n.
slot_addr  in  4*AW  slot addresses; slot n at [n*AW +: AW].
slot_we  out  4  data-valid or write strobe per slot; at most one bit high.
data_out  out  32  returned word, shared by all slots.
sdram_addr  out  AW  word address to SDRAM.
sdram_rd  out  1  read request; held until acknowledged.
sdram_ack  in  1  controller accepted the request.
data_rdy  in  1  one-cycle pulse; data_read is valid.
data_read  in  32  SDRAM read data.

Behaviour:
- Reset values: slot_we=0, data_out=0, sdram_addr=0, sdram_rd=0, state IDLE, selected index 0.
- States: IDLE, WAIT_ACK, WAIT_DATA, DELIVER.
- IDLE:
  - If any slot_req bit is high, select the lowest-numbered requesting slot (fixed priority).
  - Latch the index and latch the raw slot_addr as lat_addr.
  - sdram_addr <= slot_addr[idx] + SLOTn_OFFSET, truncated to AW bits; overflow wraps modulo 2^AW.
  - sdram_rd <= 1, then go to WAIT_ACK.
  - With no request, remain in IDLE with all strobes low.
- WAIT_ACK: hold sdram_rd and sdram_addr stable. When sdram_ack is high, sdram_rd <= 0 on that edge and go to WAIT_DATA.
- WAIT_DATA:
  - On data_rdy: data_out <= data_read; slot_we[idx] <= 1; go to DELIVER.
  - data_rdy while in WAIT_ACK is ignored; the controller never issues it there.
- DELIVER:
  - Each cycle, compare slot_addr[idx] with lat_addr.
  - Mismatch (slot moved on): clear slot_we immediately and return to IDLE. The word is discarded, because the cache would tag it with the wrong address. The slot re-arbitrates if it still requests.
  - Match and slot_cen=1: the strobe is consumed on this edge. slot_we <= 0 and go to IDLE.
  - Match and slot_cen=0: hold slot_we and data_out.
- Latency:
  - Request to sdram_rd: 1 cycle.
  - data_rdy to slot_we: 1 cycle.
  - Minimum gap between two transactions: 1 IDLE cycle. This lets the slot's combinational req reflect the updated cache.
- A slot_req that drops during WAIT_ACK or WAIT_DATA does not abort the SDRAM access. The word is still delivered subject to the DELIVER address check.
- Reset mid-transaction returns to IDLE next cycle with all outputs cleared. The SDRAM controller is reset by the same rst.
- data_out changes only on data_rdy in WAIT_DATA.

Optional Feature:
JT1943_ARB_RR_EN
- Defined: round-robin arbitration. The search starts at slot (last_served+1) mod 4, and last_served updates at DELIVER exit, whether consumed or aborted. last_served resets to 3, so slot 0 is first.
- Undefined: fixed priority, slot 0 highest. No pointer register.

Test Plan:
- Single request: slot_req=4'b0010, slot1 addr=0x00100, SLOT1_OFFSET=0x20000. Expected:
  - sdram_addr=0x20100 and sdram_rd high one cycle after the request.
  - After ack and data_rdy with data_read=0xDEADBEEF: data_out=0xDEADBEEF and slot_we=4'b0010 held until the first slot_cen=1 edge, then cleared.
- Contention: slot_req=4'b1011 held, every access served. Expected:
  - Fixed priority serves slot 0 repeatedly.
  - With JT1943_ARB_RR_EN, the serve order is 0,1,3,0.
- Address change in DELIVER: slot_cen tied low; slot 2 addr changes from 0x40 to 0x44 after data_rdy. Expected: slot_we drops the same cycle, state returns to IDLE, and a new read is issued for 0x44.
- Offset wrap: AW=22, SLOT3_OFFSET=0x3FFFF0, slot 3 addr=0x20. Expected: sdram_addr=0x000010.
- Delayed ack: sdram_ack low for 5 cycles. Expected: sdram_rd and sdram_addr stay constant and no slot_we is asserted; sdram_rd drops on the ack edge.
- Reset asserted in WAIT_DATA. Expected: the next cycle shows sdram_rd=0 and slot_we=0, and a later data_rdy produces no strobe.
